// File: rtl/dds_sweep_ctrl_if.sv
// Write-bus bundle between the sweep sequencer, a host writer and the DDS core.
// Latency: none (wires only).
// Backpressure: host_ready qualifies host_wr; the DDS side (wr/waddr/wdata) has no backpressure.
// Signals:
//   host_wr/host_waddr/host_wdata - host write request, held until host_ready
//   host_ready                    - host write accepted this cycle when host_wr=1
//   wr/waddr/wdata                - registered DDS register write strobe, address, data
// Modports: master = sequencer view (drives DDS bus and host_ready), slave = peer view.
interface dds_sweep_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          host_wr;
  logic [AW-1:0] host_waddr;
  logic [DW-1:0] host_wdata;
  logic          host_ready;
  logic          wr;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  modport master (
    input  host_wr, host_waddr, host_wdata,
    output host_ready, wr, waddr, wdata
  );

  modport slave (
    output host_wr, host_waddr, host_wdata,
    input  host_ready, wr, waddr, wdata
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer: enable, step frequency word over N points with dwell, disable.
// Latency: start -> enable write on bus 2 edges later; frequency writes 1+dwell cycles apart.
// Backpressure: sweep writes own the bus in EN_WR/FREQ_WR/DIS_WR; host_ready drops then and host waits.
// Ports:
//   clk, rst (async active-high)            - clock and reset
//   start, stop                             - one-cycle launch / abort pulses
//   start_word, step_word, n_pts, dwell     - sweep configuration, sampled on accepted start
//   bus (dds_sweep_ctrl_if.master)          - host write port in, DDS register write bus out
//   busy, done, pt_idx                      - status: active, end pulse, current point index
// Optional: define DDS_SWEEP_LOOP_EN to add the 'loop' input (sweep repeats until stop).
module dds_sweep_ctrl #(
  parameter int            AW        = 16,
  parameter int            DW        = 16,
  parameter int            DWELL_W   = 16,
  parameter logic [AW-1:0] FREQ_ADDR = AW'(16'h0020),
  parameter logic [AW-1:0] CTRL_ADDR = AW'(16'h0030),
  parameter logic [DW-1:0] CTRL_ON   = DW'(16'h000F),
  parameter logic [DW-1:0] CTRL_OFF  = DW'(16'h0000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DW-1:0]      start_word,
  input  logic [DW-1:0]      step_word,
  input  logic [15:0]        n_pts,
  input  logic [DWELL_W-1:0] dwell,
`ifdef DDS_SWEEP_LOOP_EN
  input  logic               loop,
`endif
  dds_sweep_ctrl_if.master   bus,
  output logic               busy,
  output logic               done,
  output logic [15:0]        pt_idx
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EN_WR   = 3'd1,
    FREQ_WR = 3'd2,
    DWELL   = 3'd3,
    DIS_WR  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      cur_q, cur_d;
  logic [DW-1:0]      step_q, step_d;
  logic [15:0]        npts_q, npts_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [15:0]        pt_idx_q, pt_idx_d;
  logic               wr_q, wr_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               done_q, done_d;
`ifdef DDS_SWEEP_LOOP_EN
  logic               loop_q, loop_d;
  logic [DW-1:0]      base_q, base_d;
`endif

  logic swp_req;
  logic last_pt;

  assign swp_req = (state_q == EN_WR) || (state_q == FREQ_WR) || (state_q == DIS_WR);
  // npts_q is never 0 (clamped on start), so the subtraction cannot wrap.
  assign last_pt = (pt_idx_q >= (npts_q - 16'd1));

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    step_d      = step_q;
    npts_d      = npts_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    pt_idx_d    = pt_idx_q;
    wr_d        = 1'b0;
    waddr_d     = '0;
    wdata_d     = '0;
    done_d      = 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
    loop_d      = loop_q;
    base_d      = base_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = EN_WR;
          cur_d    = start_word;
          step_d   = step_word;
          npts_d   = (n_pts == 16'd0) ? 16'd1 : n_pts;
          dwell_d  = (dwell == '0) ? DWELL_W'(1) : dwell;
          pt_idx_d = 16'd0;
`ifdef DDS_SWEEP_LOOP_EN
          loop_d   = loop;
          base_d   = start_word;
`endif
        end
      end
      EN_WR: begin
        wr_d    = 1'b1;
        waddr_d = CTRL_ADDR;
        wdata_d = CTRL_ON;
        state_d = stop ? DIS_WR : FREQ_WR;
      end
      FREQ_WR: begin
        wr_d        = 1'b1;
        waddr_d     = FREQ_ADDR;
        wdata_d     = cur_q;
        dwell_cnt_d = dwell_q;
        state_d     = stop ? DIS_WR : DWELL;
      end
      DWELL: begin
        if (stop) begin
          state_d = DIS_WR;
        end else if (dwell_cnt_q <= DWELL_W'(1)) begin
          if (!last_pt) begin
            cur_d    = cur_q + step_q;
            pt_idx_d = pt_idx_q + 16'd1;
            state_d  = FREQ_WR;
          end else begin
`ifdef DDS_SWEEP_LOOP_EN
            if (loop_q) begin
              cur_d    = base_q;
              pt_idx_d = 16'd0;
              state_d  = FREQ_WR;
            end else begin
              state_d  = DIS_WR;
            end
`else
            state_d = DIS_WR;
`endif
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end
      DIS_WR: begin
        wr_d    = 1'b1;
        waddr_d = CTRL_ADDR;
        wdata_d = CTRL_OFF;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Host slot: only when the sequencer is not issuing, so the two never collide.
    if (!swp_req && bus.host_wr) begin
      wr_d    = 1'b1;
      waddr_d = bus.host_waddr;
      wdata_d = bus.host_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      step_q      <= '0;
      npts_q      <= 16'd1;
      dwell_q     <= DWELL_W'(1);
      dwell_cnt_q <= '0;
      pt_idx_q    <= 16'd0;
      wr_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
      loop_q      <= 1'b0;
      base_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      step_q      <= step_d;
      npts_q      <= npts_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      pt_idx_q    <= pt_idx_d;
      wr_q        <= wr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
`ifdef DDS_SWEEP_LOOP_EN
      loop_q      <= loop_d;
      base_q      <= base_d;
`endif
    end
  end

  assign bus.host_ready = ~swp_req;
  assign bus.wr         = wr_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign pt_idx         = pt_idx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed sweeps with an expected-write queue and a bus monitor.
// Latency: n/a.
// Backpressure: host writer holds host_wr until host_ready is seen.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop;
  logic [15:0] start_word, step_word, n_pts, dwell;
  logic        busy, done;
  logic [15:0] pt_idx;
`ifdef DDS_SWEEP_LOOP_EN
  logic        loop;
`endif

  dds_sweep_ctrl_if #(.AW(16), .DW(16)) bus ();

  dds_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .start_word (start_word),
    .step_word  (step_word),
    .n_pts      (n_pts),
    .dwell      (dwell),
`ifdef DDS_SWEEP_LOOP_EN
    .loop       (loop),
`endif
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .pt_idx     (pt_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        dn;
    int          gap;   // cycles since previous sweep write; 0 = unchecked
    bit          host;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   last_swp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d, input logic dn,
                      input int gap, input bit host);
    exp_t e;
    e.addr = a; e.data = d; e.dn = dn; e.gap = gap; e.host = host;
    expq.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.wr) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected (cycle %0d)",
                     bus.waddr, bus.wdata, cyc);
          end else begin
            e = expq.pop_front();
            check("bus_addr", bus.waddr, e.addr);
            check("bus_data", bus.wdata, e.data);
            check("done_with_write", done, e.dn);
            if (!e.host) begin
              if (e.gap != 0) check("write_spacing", cyc - last_swp, e.gap);
              last_swp = cyc;
            end
          end
        end else if (done) begin
          check("done_without_write", done, 1'b0);
        end
      end
    end
  endtask

  task automatic sweep_start(input logic [15:0] sw, input logic [15:0] st,
                             input logic [15:0] np, input logic [15:0] dw);
    @(posedge clk); #1;
    start_word = sw; step_word = st; n_pts = np; dwell = dw;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && !busy) break;
    end
    check({name, "_queue_empty"}, expq.size(), 0);
    check({name, "_idle"}, busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    start_word = '0; step_word = '0; n_pts = '0; dwell = '0;
    bus.host_wr = 1'b0; bus.host_waddr = '0; bus.host_wdata = '0;
`ifdef DDS_SWEEP_LOOP_EN
    loop = 1'b0;
`endif
    #2 rst = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wr", bus.wr, 1'b0);
    check("rst_waddr", bus.waddr, 16'h0);
    check("rst_wdata", bus.wdata, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pt_idx", pt_idx, 16'h0);
    check("rst_host_ready", bus.host_ready, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic sweep: 3 points, dwell 4
    push(16'h30, 16'h000F, 1'b0, 0, 1'b0);
    push(16'h20, 16'h0002, 1'b0, 1, 1'b0);
    push(16'h20, 16'h0003, 1'b0, 5, 1'b0);
    push(16'h20, 16'h0004, 1'b0, 5, 1'b0);
    push(16'h30, 16'h0000, 1'b1, 5, 1'b0);
    sweep_start(16'h0002, 16'h0001, 16'd3, 16'd4);
    @(negedge clk);
    check("basic_busy", busy, 1'b1);
    check("basic_pt_idx0", pt_idx, 16'd0);
    repeat (6) @(negedge clk);
    check("basic_pt_idx1", pt_idx, 16'd1);
    wait_drain("basic");

    // Wrap with dwell 0 treated as 1
    push(16'h30, 16'h000F, 1'b0, 0, 1'b0);
    push(16'h20, 16'hFFFF, 1'b0, 1, 1'b0);
    push(16'h20, 16'h0001, 1'b0, 2, 1'b0);
    push(16'h30, 16'h0000, 1'b1, 2, 1'b0);
    sweep_start(16'hFFFF, 16'h0002, 16'd2, 16'd0);
    wait_drain("wrap");

    // n_pts 0 treated as 1
    push(16'h30, 16'h000F, 1'b0, 0, 1'b0);
    push(16'h20, 16'h0055, 1'b0, 1, 1'b0);
    push(16'h30, 16'h0000, 1'b1, 3, 1'b0);
    sweep_start(16'h0055, 16'h0001, 16'd0, 16'd2);
    wait_drain("npts0");

    // Arbitration: first host write taken in IDLE, second held through EN_WR/FREQ_WR
    push(16'h40, 16'h1234, 1'b0, 0, 1'b1);
    push(16'h30, 16'h000F, 1'b0, 0, 1'b0);
    push(16'h20, 16'h0100, 1'b0, 1, 1'b0);
    push(16'h41, 16'h5678, 1'b0, 0, 1'b1);
    push(16'h20, 16'h0200, 1'b0, 5, 1'b0);
    push(16'h30, 16'h0000, 1'b1, 5, 1'b0);
    @(posedge clk); #1;
    start_word = 16'h0100; step_word = 16'h0100; n_pts = 16'd2; dwell = 16'd4;
    start = 1'b1;
    bus.host_wr = 1'b1; bus.host_waddr = 16'h0040; bus.host_wdata = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    bus.host_waddr = 16'h0041; bus.host_wdata = 16'h5678;
    @(negedge clk);
    check("host_ready_en_wr", bus.host_ready, 1'b0);
    @(negedge clk);
    check("host_ready_freq_wr", bus.host_ready, 1'b0);
    @(negedge clk);
    check("host_ready_dwell", bus.host_ready, 1'b1);
    @(posedge clk); #1;
    bus.host_wr = 1'b0;
    wait_drain("arb");

    // Stop in the second dwell cycle after point 0
    push(16'h30, 16'h000F, 1'b0, 0, 1'b0);
    push(16'h20, 16'h0100, 1'b0, 1, 1'b0);
    push(16'h30, 16'h0000, 1'b1, 3, 1'b0);
    sweep_start(16'h0100, 16'h0001, 16'd5, 16'd4);
    repeat (3) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    check("stop_busy_in_dis", busy, 1'b1);
    @(negedge clk);
    check("stop_busy_after", busy, 1'b0);
    wait_drain("stop");

    // Start during DWELL is ignored
    push(16'h30, 16'h000F, 1'b0, 0, 1'b0);
    push(16'h20, 16'h0200, 1'b0, 1, 1'b0);
    push(16'h20, 16'h0210, 1'b0, 4, 1'b0);
    push(16'h30, 16'h0000, 1'b1, 4, 1'b0);
    sweep_start(16'h0200, 16'h0010, 16'd2, 16'd3);
    repeat (2) @(posedge clk);
    #1;
    start_word = 16'h0999; step_word = 16'h0000; n_pts = 16'd7; dwell = 16'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("ign_start");

    // Reset in DWELL while the frequency write is on the bus
    push(16'h30, 16'h000F, 1'b0, 0, 1'b0);
    push(16'h20, 16'h0300, 1'b0, 1, 1'b0);
    sweep_start(16'h0300, 16'h0001, 16'd4, 16'd6);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_wr", bus.wr, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_waddr", bus.waddr, 16'h0);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("arst_queue_empty", expq.size(), 0);

`ifdef DDS_SWEEP_LOOP_EN
    // Looping sweep until stop
    push(16'h30, 16'h000F, 1'b0, 0, 1'b0);
    push(16'h20, 16'h0010, 1'b0, 1, 1'b0);
    push(16'h20, 16'h0020, 1'b0, 2, 1'b0);
    push(16'h20, 16'h0010, 1'b0, 2, 1'b0);
    push(16'h20, 16'h0020, 1'b0, 2, 1'b0);
    push(16'h30, 16'h0000, 1'b1, 2, 1'b0);
    loop = 1'b1;
    sweep_start(16'h0010, 16'h0010, 16'd2, 16'd1);
    repeat (8) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    loop = 1'b0;
    wait_drain("loop");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
